// File: rtl/unary_stream_gen_if.sv
// Handshake bundle for unary_stream_gen: binary count in, unary bitstream out.
// slave is the generator side, master is the source/consumer side.
interface unary_stream_gen_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );

  modport master (
    output in_valid,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );
endinterface

// File: rtl/unary_stream_gen.sv
// Expands a binary count N into a 2^WIDTH-1 cycle unary stream holding N ones.
// Define USTREAM_SPREAD_EN to spread the ones evenly instead of thermometer order.
module unary_stream_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  unary_stream_gen_if.slave   bus,
  output logic                busy
);

  localparam int unsigned      WINDOW   = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(WINDOW - 1);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_armed;
  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_count;
  logic             w_emit;
  logic             w_last;
  logic             w_xfer;
  logic             w_accept;
  logic             w_bit_raw;

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_emit   = (r_state == S_EMIT);
  assign w_last   = w_emit && (r_idx == LAST_IDX);
  assign w_xfer   = bus.out_valid && bus.out_ready;
  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    w_state_nxt  = r_state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = r_armed;
        if (w_accept) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        // Only the final transfer of a window opens the input, so a
        // back-to-back count continues in EMIT without a bubble.
        bus.in_ready  = w_last && bus.out_ready;
        if (w_xfer && w_last && !w_accept) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_count <= bus.in_count;
    end else if (w_xfer) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef USTREAM_SPREAD_EN
  localparam logic [WIDTH:0] WIN_EXT = (WIDTH + 1)'(WINDOW);

  logic [WIDTH:0] r_acc;
  logic [WIDTH:0] w_sum;

  // Bresenham-style spreading: acc stays below WINDOW, so sum fits WIDTH+1 bits
  assign w_sum     = r_acc + {1'b0, r_count};
  assign w_bit_raw = (w_sum >= WIN_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_xfer) begin
      if (w_bit_raw) begin
        r_acc <= w_sum - WIN_EXT;
      end else begin
        r_acc <= w_sum;
      end
    end
  end
`else
  assign w_bit_raw = (r_idx < r_count);
`endif

  assign bus.out_bit  = w_emit && w_bit_raw;
  assign bus.out_last = w_last;

endmodule
